// File: rtl/cpu6_irq_ctrl.sv
// Machine-mode interrupt controller: captures timer/software/external sources,
// arbitrates them against mie/mstatus.MIE and hands a frozen mcause to the pipeline.
module cpu6_irq_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            lic_timer_interrupt,
    input  logic            lic_mtimecmp_write_ena,
    input  logic            ext_irq,
    input  logic            msip_set,
    input  logic            msip_clr,
    input  logic [XLEN-1:0] mie_write,
    input  logic            mie_write_ena,
    input  logic            mstatus_mie_write,
    input  logic            mstatus_mie_write_ena,
    input  logic            mret,
    input  logic            irq_ack,
    output logic            irq_req,
    output logic [XLEN-1:0] irq_cause,
    output logic [XLEN-1:0] mip_read,
    output logic [XLEN-1:0] mie_read,
    output logic            mstatus_mie,
    output logic            mstatus_mpie
);

    localparam int MSI_BIT = 3;
    localparam int MTI_BIT = 7;
    localparam int MEI_BIT = 11;
    localparam logic [XLEN-1:0] MIE_MASK  = {{(XLEN-12){1'b0}}, 12'h888};
    localparam logic [XLEN-1:0] CAUSE_MSI = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
    localparam logic [XLEN-1:0] CAUSE_MTI = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
    localparam logic [XLEN-1:0] CAUSE_MEI = {1'b1, {(XLEN-5){1'b0}}, 4'd11};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t            state_r, next_state_s;
    logic              ext_irq_r, mtip_pend_r, msip_pend_r;
    logic [XLEN-1:0]   mie_r;
    logic              mstatus_mie_r, mstatus_mpie_r;
    logic              irq_req_r, irq_req_next_s;
    logic [XLEN-1:0]   irq_cause_r, irq_cause_next_s;
    logic [XLEN-1:0]   mip_s, pend_en_s;
    logic              take_s, ack_s, mtip_clr_s;
    logic              unused_s;

    // Fixed priority MEI > MSI > MTI over enabled pending sources.
    function automatic logic [XLEN-1:0] pick_cause(input logic [XLEN-1:0] pend_en);
        if (pend_en[MEI_BIT])      return CAUSE_MEI;
        else if (pend_en[MSI_BIT]) return CAUSE_MSI;
        else if (pend_en[MTI_BIT]) return CAUSE_MTI;
        else                       return {XLEN{1'b0}};
    endfunction

    assign unused_s = ^mie_write;

    // Pending vector, enable gating and acknowledge qualification.
    always_comb begin
        mip_s          = {XLEN{1'b0}};
        mip_s[MEI_BIT] = ext_irq_r;
        mip_s[MTI_BIT] = mtip_pend_r;
        mip_s[MSI_BIT] = msip_pend_r;
        pend_en_s      = mip_s & mie_r;
        take_s         = mstatus_mie_r & (|pend_en_s);
        ack_s          = (state_r == REQ) & irq_ack;
        mtip_clr_s     = lic_mtimecmp_write_ena | (ack_s & (irq_cause_r == CAUSE_MTI));
    end

    // Interrupt sources and mie; set beats clear on the sticky bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_irq_r   <= 1'b0;
            mtip_pend_r <= 1'b0;
            msip_pend_r <= 1'b0;
            mie_r       <= {XLEN{1'b0}};
        end else begin
            ext_irq_r <= ext_irq;
            if (lic_timer_interrupt)  mtip_pend_r <= 1'b1;
            else if (mtip_clr_s)      mtip_pend_r <= 1'b0;
            else                      mtip_pend_r <= mtip_pend_r;
            if (msip_set)             msip_pend_r <= 1'b1;
            else if (msip_clr)        msip_pend_r <= 1'b0;
            else                      msip_pend_r <= msip_pend_r;
            if (mie_write_ena)        mie_r <= mie_write & MIE_MASK;
            else                      mie_r <= mie_r;
        end
    end

    // MIE/MPIE stacking: trap entry beats mret beats a CSR write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mstatus_mie_r  <= 1'b0;
            mstatus_mpie_r <= 1'b0;
        end else if (ack_s) begin
            mstatus_mpie_r <= mstatus_mie_r;
            mstatus_mie_r  <= 1'b0;
        end else if (mret) begin
            mstatus_mie_r  <= mstatus_mpie_r;
            mstatus_mpie_r <= 1'b1;
        end else if (mstatus_mie_write_ena) begin
            mstatus_mie_r  <= mstatus_mie_write;
            mstatus_mpie_r <= mstatus_mpie_r;
        end else begin
            mstatus_mie_r  <= mstatus_mie_r;
            mstatus_mpie_r <= mstatus_mpie_r;
        end
    end

    // State register with registered request/cause outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            irq_req_r   <= 1'b0;
            irq_cause_r <= {XLEN{1'b0}};
        end else begin
            state_r     <= next_state_s;
            irq_req_r   <= irq_req_next_s;
            irq_cause_r <= irq_cause_next_s;
        end
    end

    // Next-state logic; a request, once raised, is only retired by irq_ack.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (take_s)  next_state_s = REQ;     else next_state_s = IDLE;
            REQ:     if (irq_ack) next_state_s = HANDLER; else next_state_s = REQ;
            HANDLER: if (mret)    next_state_s = IDLE;    else next_state_s = HANDLER;
            default: next_state_s = IDLE;
        endcase
    end

    // Output logic: cause is sampled only when leaving IDLE, then frozen.
    always_comb begin
        irq_req_next_s = (next_state_s == REQ);
        if ((state_r == IDLE) && take_s) irq_cause_next_s = pick_cause(pend_en_s);
        else                             irq_cause_next_s = irq_cause_r;
    end

    assign irq_req      = irq_req_r;
    assign irq_cause    = irq_cause_r;
    assign mip_read     = mip_s;
    assign mie_read     = mie_r;
    assign mstatus_mie  = mstatus_mie_r;
    assign mstatus_mpie = mstatus_mpie_r;

endmodule

// File: tb/tb_cpu6_irq_ctrl.sv
// Bench for cpu6_irq_ctrl: directed scenarios checked against a source-table
// model every cycle, plus hand-computed literal expectations.
module tb_cpu6_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lic_timer_interrupt = 1'b0, lic_mtimecmp_write_ena = 1'b0;
    logic        ext_irq = 1'b0, msip_set = 1'b0, msip_clr = 1'b0;
    logic [31:0] mie_write = 32'h0;
    logic        mie_write_ena = 1'b0, mstatus_mie_write = 1'b0, mstatus_mie_write_ena = 1'b0;
    logic        mret = 1'b0, irq_ack = 1'b0;
    logic        irq_req, mstatus_mie, mstatus_mpie;
    logic [31:0] irq_cause, mip_read, mie_read;

    int n_cmp = 0;
    int n_err = 0;

    cpu6_irq_ctrl #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .lic_timer_interrupt(lic_timer_interrupt),
        .lic_mtimecmp_write_ena(lic_mtimecmp_write_ena),
        .ext_irq(ext_irq), .msip_set(msip_set), .msip_clr(msip_clr),
        .mie_write(mie_write), .mie_write_ena(mie_write_ena),
        .mstatus_mie_write(mstatus_mie_write), .mstatus_mie_write_ena(mstatus_mie_write_ena),
        .mret(mret), .irq_ack(irq_ack),
        .irq_req(irq_req), .irq_cause(irq_cause), .mip_read(mip_read), .mie_read(mie_read),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie)
    );

    always #5 clk = ~clk;

    // Model: sources listed in priority order with their mip bit and cause code.
    int          src_bit   [3] = '{11, 3, 7};
    logic [31:0] src_cause [3] = '{32'h8000000B, 32'h80000003, 32'h80000007};

    typedef struct packed {
        logic [31:0] mie;
        logic        ext, mtip, msip, smie, smpie;
        logic [1:0]  phase;   // 0 = waiting, 1 = requesting, 2 = in handler
        logic [31:0] cause;
    } model_t;

    model_t m;

    function automatic logic [31:0] mip_of(model_t c);
        logic [31:0] p;
        p = (32'(c.ext) << 11) | (32'(c.mtip) << 7) | (32'(c.msip) << 3);
        return p;
    endfunction

    function automatic model_t step(model_t c);
        model_t n;
        logic [31:0] en;
        logic acked;
        n = c;
        en = mip_of(c) & c.mie;
        acked = (c.phase == 2'd1) && irq_ack;
        n.ext = ext_irq;
        if (lic_timer_interrupt) n.mtip = 1'b1;
        else if (lic_mtimecmp_write_ena || (acked && c.cause == 32'h80000007)) n.mtip = 1'b0;
        if (msip_set) n.msip = 1'b1;
        else if (msip_clr) n.msip = 1'b0;
        if (mie_write_ena) n.mie = mie_write & 32'h00000888;
        if (acked) begin n.smpie = c.smie; n.smie = 1'b0; end
        else if (mret) begin n.smie = c.smpie; n.smpie = 1'b1; end
        else if (mstatus_mie_write_ena) n.smie = mstatus_mie_write;
        if (c.phase == 2'd0 && c.smie && en != 32'h0) begin
            n.phase = 2'd1;
            for (int i = 2; i >= 0; i--)
                if (en[src_bit[i]]) n.cause = src_cause[i];
        end else if (acked) n.phase = 2'd2;
        else if (c.phase == 2'd2 && mret) n.phase = 2'd0;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= step(m);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model on the falling edge.
    always @(negedge clk) begin
        chk("irq_req",      {31'h0, irq_req},      {31'h0, m.phase == 2'd1});
        chk("irq_cause",    irq_cause,             m.cause);
        chk("mip_read",     mip_read,              mip_of(m));
        chk("mie_read",     mie_read,              m.mie);
        chk("mstatus_mie",  {31'h0, mstatus_mie},  {31'h0, m.smie});
        chk("mstatus_mpie", {31'h0, mstatus_mpie}, {31'h0, m.smpie});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_mie(input logic [31:0] v);
        mie_write = v; mie_write_ena = 1'b1; tick(); mie_write_ena = 1'b0;
    endtask

    task automatic wr_mstatus(input logic v);
        mstatus_mie_write = v; mstatus_mie_write_ena = 1'b1; tick(); mstatus_mie_write_ena = 1'b0;
    endtask

    task automatic pulse_ack();  irq_ack = 1'b1; tick(); irq_ack = 1'b0; endtask
    task automatic pulse_mret(); mret = 1'b1; tick(); mret = 1'b0; endtask

    initial begin
        // 1: reset with ext_irq high, mie = 0
        ext_irq = 1'b1;
        tick(); tick();
        chk("t1 req in reset", {31'h0, irq_req}, 32'h0);
        chk("t1 mip in reset", mip_read, 32'h0);
        reset = 1'b0;
        tick();
        chk("t1 mip after", mip_read, 32'h00000800);
        tick(); tick();
        chk("t1 no req", {31'h0, irq_req}, 32'h0);
        ext_irq = 1'b0;

        // 2: timer interrupt latency and trap entry
        wr_mie(32'h00000080);
        wr_mstatus(1'b1);
        tick();
        lic_timer_interrupt = 1'b1; tick(); lic_timer_interrupt = 1'b0;
        chk("t2 mip N+1", mip_read, 32'h00000080);
        chk("t2 req N+1", {31'h0, irq_req}, 32'h0);
        tick();
        chk("t2 req N+2", {31'h0, irq_req}, 32'h1);
        chk("t2 cause", irq_cause, 32'h80000007);
        tick(); tick();
        chk("t2 held", {31'h0, irq_req}, 32'h1);
        pulse_ack();
        chk("t2 mip ack", mip_read, 32'h0);
        chk("t2 mie ack", {31'h0, mstatus_mie}, 32'h0);
        chk("t2 mpie ack", {31'h0, mstatus_mpie}, 32'h1);
        chk("t2 req ack", {31'h0, irq_req}, 32'h0);
        pulse_mret();
        chk("t2 mie mret", {31'h0, mstatus_mie}, 32'h1);

        // 3: priority among simultaneous sources
        wr_mie(32'hFFFFFFFF);
        chk("t3 mie mask", mie_read, 32'h00000888);
        ext_irq = 1'b1; msip_set = 1'b1; lic_timer_interrupt = 1'b1;
        tick();
        ext_irq = 1'b0; msip_set = 1'b0; lic_timer_interrupt = 1'b0;
        tick();
        chk("t3 cause mei", irq_cause, 32'h8000000B);
        pulse_ack(); pulse_mret(); tick();
        chk("t3 cause msi", irq_cause, 32'h80000003);
        chk("t3 req msi", {31'h0, irq_req}, 32'h1);
        msip_clr = 1'b1; tick(); msip_clr = 1'b0;
        pulse_ack(); pulse_mret(); tick();
        chk("t3 cause mti", irq_cause, 32'h80000007);
        pulse_ack(); pulse_mret();
        chk("t3 mip idle", mip_read, 32'h0);

        // 4: globally disabled timer, mtimecmp rewrite, msip set/clr together
        wr_mstatus(1'b0);
        lic_timer_interrupt = 1'b1; tick(); lic_timer_interrupt = 1'b0;
        chk("t4 mtip set", mip_read, 32'h00000080);
        lic_mtimecmp_write_ena = 1'b1; tick(); lic_mtimecmp_write_ena = 1'b0;
        chk("t4 mtip clr", mip_read, 32'h0);
        chk("t4 no req", {31'h0, irq_req}, 32'h0);
        msip_set = 1'b1; msip_clr = 1'b1; tick(); msip_set = 1'b0; msip_clr = 1'b0;
        chk("t4 msip wins", mip_read, 32'h00000008);
        msip_clr = 1'b1; tick(); msip_clr = 1'b0;
        wr_mstatus(1'b1);

        // 5: request held after source and enable drop; ack + mret together
        wr_mie(32'h00000800);
        ext_irq = 1'b1; tick(); tick();
        chk("t5 req", {31'h0, irq_req}, 32'h1);
        ext_irq = 1'b0;
        wr_mie(32'h0);
        tick();
        chk("t5 held", {31'h0, irq_req}, 32'h1);
        chk("t5 cause", irq_cause, 32'h8000000B);
        irq_ack = 1'b1; mret = 1'b1; tick(); irq_ack = 1'b0; mret = 1'b0;
        chk("t5 mie", {31'h0, mstatus_mie}, 32'h0);
        chk("t5 mpie", {31'h0, mstatus_mpie}, 32'h1);
        chk("t5 req off", {31'h0, irq_req}, 32'h0);

        // 6: asynchronous reset while in the handler
        wr_mie(32'h00000888);
        msip_set = 1'b1; tick(); msip_set = 1'b0;
        chk("t6 pre mip", mip_read, 32'h00000008);
        #1 reset = 1'b1;
        #1;
        chk("t6 async mip", mip_read, 32'h0);
        chk("t6 async mie", mie_read, 32'h0);
        chk("t6 async cause", irq_cause, 32'h0);
        chk("t6 async mpie", {31'h0, mstatus_mpie}, 32'h0);
        tick();
        reset = 1'b0;
        wr_mie(32'h00000008);
        wr_mstatus(1'b1);
        msip_set = 1'b1; tick(); msip_set = 1'b0;
        tick();
        chk("t6 restart req", {31'h0, irq_req}, 32'h1);
        chk("t6 restart cause", irq_cause, 32'h80000003);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
